// File: rtl/tournament_predictor_param.sv
// rtl/tournament_predictor_param.sv - tournament branch predictor: local, global and chooser counter tables
module tournament_predictor_param #(
    parameter int LOCAL_IDX_BITS   = 4,
    parameter int GHR_BITS         = 6,
    parameter int CHOOSER_IDX_BITS = 4,
    parameter int CTR_BITS         = 2,
    parameter int USE_GSHARE       = 0,
    parameter int PC_SHIFT         = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    input  logic [31:0] pred_offset,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        prediction,
    output logic [31:0] pred_target,
    output logic        ready
);
    localparam int LG_MAX   = (LOCAL_IDX_BITS > GHR_BITS) ? LOCAL_IDX_BITS : GHR_BITS;
    localparam int PTR_BITS = (LG_MAX > CHOOSER_IDX_BITS) ? LG_MAX : CHOOSER_IDX_BITS;
    localparam int MSB      = CTR_BITS - 1;
    localparam logic [31:0] LOCAL_DEPTH   = 32'd1 << LOCAL_IDX_BITS;
    localparam logic [31:0] GLOBAL_DEPTH  = 32'd1 << GHR_BITS;
    localparam logic [31:0] CHOOSER_DEPTH = 32'd1 << CHOOSER_IDX_BITS;
    localparam logic [PTR_BITS-1:0] PTR_LAST   = '1;
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1) << MSB;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_WEAK_T - CTR_BITS'(1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state, state_next;

    logic [CTR_BITS-1:0] local_tbl   [LOCAL_DEPTH];
    logic [CTR_BITS-1:0] global_tbl  [GLOBAL_DEPTH];
    logic [CTR_BITS-1:0] chooser_tbl [CHOOSER_DEPTH];

    logic [PTR_BITS-1:0] ptr;
    logic [31:0]         ptr_ext;
    logic [GHR_BITS-1:0] ghr;
    logic                snap_valid, snap_loc_msb, snap_glb_msb;
    logic [GHR_BITS-1:0] snap_gidx;

    logic [LOCAL_IDX_BITS-1:0]   p_lidx, u_lidx;
    logic [CHOOSER_IDX_BITS-1:0] p_cidx, u_cidx;
    logic [GHR_BITS-1:0]         p_pcg, u_pcg, p_gidx, u_gidx_raw, u_gidx;
    logic                        l_msb, g_msb, c_msb, cho_train;
    logic [CTR_BITS-1:0]         loc_next, glb_next, cho_next;
    logic                        unused_pc_bits;

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    assign ptr_ext        = 32'(ptr);
    assign unused_pc_bits = ^upd_pc;

    assign p_lidx = pred_pc[PC_SHIFT +: LOCAL_IDX_BITS];
    assign u_lidx = upd_pc[PC_SHIFT +: LOCAL_IDX_BITS];
    assign p_cidx = pred_pc[PC_SHIFT +: CHOOSER_IDX_BITS];
    assign u_cidx = upd_pc[PC_SHIFT +: CHOOSER_IDX_BITS];
    assign p_pcg  = pred_pc[PC_SHIFT +: GHR_BITS];
    assign u_pcg  = upd_pc[PC_SHIFT +: GHR_BITS];

    assign p_gidx     = (USE_GSHARE != 0) ? (ghr ^ p_pcg) : ghr;
    assign u_gidx_raw = (USE_GSHARE != 0) ? (ghr ^ u_pcg) : ghr;
    // A resolve with a live snapshot trains the entry that actually made the prediction.
    assign u_gidx     = snap_valid ? snap_gidx : u_gidx_raw;

    assign l_msb = local_tbl[p_lidx][MSB];
    assign g_msb = global_tbl[p_gidx][MSB];
    assign c_msb = chooser_tbl[p_cidx][MSB];

    assign prediction  = (state == ST_RUN) && pred_req && (c_msb ? g_msb : l_msb);
    assign pred_target = pred_pc + pred_offset;
    assign ready       = (state == ST_RUN);

    assign loc_next  = sat_step(local_tbl[u_lidx], upd_taken);
    assign glb_next  = sat_step(global_tbl[u_gidx], upd_taken);
    assign cho_next  = sat_step(chooser_tbl[u_cidx], snap_glb_msb == upd_taken);
    assign cho_train = snap_valid && (snap_loc_msb != snap_glb_msb);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (ptr == PTR_LAST) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            ghr        <= '0;
            snap_valid <= 1'b0;
        end else if (state == ST_INIT) begin
            // Sweep shared by all tables; smaller tables stop once ptr passes their depth.
            ptr <= ptr + PTR_BITS'(1);
            if (ptr_ext < LOCAL_DEPTH)   local_tbl[ptr[LOCAL_IDX_BITS-1:0]]     <= CTR_WEAK_T;
            if (ptr_ext < GLOBAL_DEPTH)  global_tbl[ptr[GHR_BITS-1:0]]          <= CTR_WEAK_T;
            if (ptr_ext < CHOOSER_DEPTH) chooser_tbl[ptr[CHOOSER_IDX_BITS-1:0]] <= CTR_WEAK_N;
        end else begin
            if (upd_valid) begin
                local_tbl[u_lidx]  <= loc_next;
                global_tbl[u_gidx] <= glb_next;
                if (cho_train) chooser_tbl[u_cidx] <= cho_next;
                ghr        <= {ghr[GHR_BITS-2:0], upd_taken};
                snap_valid <= 1'b0;
            end
            if (pred_req) begin
                snap_valid   <= 1'b1;
                snap_gidx    <= p_gidx;
                snap_loc_msb <= l_msb;
                snap_glb_msb <= g_msb;
            end
        end
    end
endmodule

// File: tb/tb_tournament_predictor_param.sv
// tb/tb_tournament_predictor_param.sv - bench for tournament_predictor_param (plain and gshare instances)
module tb_tournament_predictor_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pred_req, upd_valid, upd_taken;
    logic [31:0] pred_pc, pred_offset, upd_pc;
    logic        prediction0, ready0, prediction1, ready1;
    logic [31:0] target0, target1;

    tournament_predictor_param dut0 (
        .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_offset(pred_offset), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .prediction(prediction0), .pred_target(target0), .ready(ready0)
    );

    tournament_predictor_param #(
        .LOCAL_IDX_BITS(4), .GHR_BITS(4), .CHOOSER_IDX_BITS(4),
        .CTR_BITS(2), .USE_GSHARE(1), .PC_SHIFT(0)
    ) dut1 (
        .clk(clk), .reset(reset), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_offset(pred_offset), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .prediction(prediction1), .pred_target(target1), .ready(ready1)
    );

    typedef struct {
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic        pred_req;
        logic [31:0] pred_pc;
        logic        chk;
        logic        exp_pred;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic s_ready0, s_ready1, s_pred0, s_pred1;
    logic [31:0] s_target0;

    // Reference model: counters as plain integers 0..3, index 0 = plain config, 1 = gshare config.
    int m_loc [2][16];
    int m_cho [2][16];
    int m_glb [2][64];
    int m_ghr [2];
    int m_cnt [2];
    bit m_run [2];
    bit m_sv  [2];
    int m_sg  [2];
    bit m_sl  [2];
    bit m_sgm [2];

    function automatic int gsz(input int c);
        return (c == 0) ? 64 : 16;
    endfunction

    function automatic int pc_field(input logic [31:0] pc, input int size);
        return int'(pc % size);
    endfunction

    function automatic int gidx(input int c, input logic [31:0] pc);
        return (c == 0) ? m_ghr[c] : (m_ghr[c] ^ pc_field(pc, gsz(c)));
    endfunction

    function automatic int clamp(input int x);
        return (x < 0) ? 0 : ((x > 3) ? 3 : x);
    endfunction

    function automatic logic model_pred(input int c);
        int li;
        if (!m_run[c] || !pred_req) return 1'b0;
        li = pc_field(pred_pc, 16);
        return (m_cho[c][li] >= 2) ? (m_glb[c][gidx(c, pred_pc)] >= 2) : (m_loc[c][li] >= 2);
    endfunction

    task automatic model_step(input int c);
        int li, gi, ng;
        bit nl, ngm;
        if (reset) begin
            m_run[c] = 0; m_cnt[c] = 0; m_ghr[c] = 0; m_sv[c] = 0;
            return;
        end
        if (!m_run[c]) begin
            m_cnt[c]++;
            if (m_cnt[c] == gsz(c)) begin
                m_run[c] = 1;
                for (int i = 0; i < 16; i++) begin m_loc[c][i] = 2; m_cho[c][i] = 1; end
                for (int i = 0; i < 64; i++) m_glb[c][i] = 2;
            end
            return;
        end
        ng  = gidx(c, pred_pc);
        nl  = m_loc[c][pc_field(pred_pc, 16)] >= 2;
        ngm = m_glb[c][ng] >= 2;
        if (upd_valid) begin
            li = pc_field(upd_pc, 16);
            gi = m_sv[c] ? m_sg[c] : gidx(c, upd_pc);
            m_loc[c][li] = clamp(m_loc[c][li] + (upd_taken ? 1 : -1));
            m_glb[c][gi] = clamp(m_glb[c][gi] + (upd_taken ? 1 : -1));
            if (m_sv[c] && (m_sl[c] != m_sgm[c]))
                m_cho[c][li] = clamp(m_cho[c][li] + ((m_sgm[c] == upd_taken) ? 1 : -1));
            m_ghr[c] = (m_ghr[c] * 2 + (upd_taken ? 1 : 0)) % gsz(c);
            m_sv[c]  = 0;
        end
        if (pred_req) begin
            m_sv[c] = 1; m_sg[c] = ng; m_sl[c] = nl; m_sgm[c] = ngm;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int exp_dut, input logic exp_pred, input string name);
        @(negedge clk);
        s_ready0 = ready0; s_ready1 = ready1; s_pred0 = prediction0; s_pred1 = prediction1;
        s_target0 = target0;
        check("ready0", {31'd0, ready0}, {31'd0, m_run[0]});
        check("ready1", {31'd0, ready1}, {31'd0, m_run[1]});
        check("pred0", {31'd0, prediction0}, {31'd0, model_pred(0)});
        check("pred1", {31'd0, prediction1}, {31'd0, model_pred(1)});
        check("target0", target0, pred_pc + pred_offset);
        check("target1", target1, pred_pc + pred_offset);
        if (exp_dut == 0) check(name, {31'd0, prediction0}, {31'd0, exp_pred});
        else if (exp_dut == 1) check(name, {31'd0, prediction1}, {31'd0, exp_pred});
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic wait_ready();
        int n0 = 0;
        int n1 = 0;
        bit done = 0;
        reset = 0; pred_req = 0; upd_valid = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(-1, 1'b0, "");
            if (s_ready0) done = 1; else n0++;
            if (!s_ready1) n1++;
        end
        check("init_len0", n0, 64);
        check("init_len1", n1, 16);
    endtask

    task automatic pulse_reset();
        reset = 1; pred_req = 0; upd_valid = 0;
        step(-1, 1'b0, "");
        wait_ready();
    endtask

    task automatic run_vec(input vec_t v, input int dut, input string name);
        upd_valid = v.upd_valid; upd_pc = v.upd_pc; upd_taken = v.upd_taken;
        pred_req = v.pred_req; pred_pc = v.pred_pc; pred_offset = $urandom;
        step(v.chk ? dut : -1, v.exp_pred, name);
        upd_valid = 0; pred_req = 0;
    endtask

    function automatic vec_t mk_upd(input logic [31:0] pc, input logic t);
        vec_t v;
        v.upd_valid = 1; v.upd_pc = pc; v.upd_taken = t;
        v.pred_req = 0; v.pred_pc = 0; v.chk = 0; v.exp_pred = 0;
        return v;
    endfunction

    function automatic vec_t mk_prb(input logic [31:0] pc, input logic e);
        vec_t v;
        v.upd_valid = 0; v.upd_pc = 0; v.upd_taken = 0;
        v.pred_req = 1; v.pred_pc = pc; v.chk = 1; v.exp_pred = e;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl0[20];
        vec_t tbl1[17];
        tbl0[0] = mk_upd(32'h4, 0);  tbl0[1] = mk_upd(32'h4, 0);  tbl0[2] = mk_prb(32'h4, 0);
        for (int i = 3; i < 8; i++) tbl0[i] = mk_upd(32'h4, 0);
        tbl0[8] = mk_prb(32'h4, 0);
        for (int i = 9; i < 15; i++) tbl0[i] = mk_upd(32'h8, 1);
        tbl0[15] = mk_prb(32'h8, 1); tbl0[16] = mk_upd(32'h8, 0); tbl0[17] = mk_prb(32'h8, 1);
        tbl0[18] = mk_upd(32'h8, 0); tbl0[19] = mk_prb(32'h8, 0);

        tbl1[0]  = mk_upd(32'h3, 0); tbl1[1]  = mk_upd(32'h3, 0); tbl1[2]  = mk_upd(32'h5, 0);
        tbl1[3]  = mk_upd(32'h5, 0); tbl1[4]  = mk_upd(32'hF, 1); tbl1[5]  = mk_upd(32'hF, 0);
        tbl1[6]  = mk_upd(32'hF, 0); tbl1[7]  = mk_prb(32'h7, 1); tbl1[8]  = mk_upd(32'h7, 0);
        tbl1[9]  = mk_prb(32'h7, 1); tbl1[10] = mk_upd(32'hF, 0); tbl1[11] = mk_upd(32'hF, 0);
        tbl1[12] = mk_upd(32'hF, 1); tbl1[13] = mk_upd(32'hF, 0); tbl1[14] = mk_prb(32'h7, 0);
        tbl1[15] = mk_upd(32'hF, 0); tbl1[16] = mk_prb(32'h7, 0);

        reset = 1; pred_req = 0; upd_valid = 0; upd_taken = 0;
        pred_pc = 0; upd_pc = 0; pred_offset = 0;
        repeat (2) @(posedge clk);
        model_step(0); model_step(1);
        #1;

        pred_req = 1; pred_pc = 32'h10; pred_offset = 32'hFFFF_FFF8;
        step(-1, 1'b0, "");
        check("reset_ready", {31'd0, s_ready0}, 32'd0);
        check("reset_pred", {31'd0, s_pred0}, 32'd0);

        reset = 0;
        for (int i = 0; i < 20; i++) step(-1, 1'b0, "");
        check("init_pred", {31'd0, s_pred0}, 32'd0);
        check("init_target", s_target0, 32'h8);
        pulse_reset();

        pred_req = 1; pred_pc = 32'h10; pred_offset = 32'hFFFF_FFF8;
        step(0, 1'b1, "run_pred");
        check("run_target", s_target0, 32'h8);
        for (int i = 0; i < 4; i++) begin
            pred_pc = 32'h100 * i + 32'h3 * i; pred_offset = $urandom;
            step(0, 1'b1, "fresh_pred");
        end
        pred_req = 0;

        foreach (tbl0[i]) run_vec(tbl0[i], 0, "tbl0");

        pulse_reset();
        for (int b = 0; b < 16; b++) begin
            logic t;
            t = (b % 2 == 0);
            pred_req = 1; pred_pc = 32'hC; pred_offset = $urandom; upd_valid = 0;
            step((b >= 8) ? 0 : -1, t, "alt_follow");
            pred_req = 0; upd_valid = 1; upd_pc = 32'hC; upd_taken = t;
            step(-1, 1'b0, "");
            upd_valid = 0;
        end

        pulse_reset();
        foreach (tbl1[i]) run_vec(tbl1[i], 1, "tbl1_gshare");

        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            pred_req = 1; pred_pc = 32'h4 + 32'h1 * i * 3; pred_offset = $urandom;
            step(0, 1'b1, "post_reset0");
            step(1, 1'b1, "post_reset1");
        end
        pred_req = 0;

        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            pred_req    = $urandom_range(0, 1);
            upd_valid   = $urandom_range(0, 1);
            upd_taken   = $urandom_range(0, 1);
            pred_pc     = $urandom;
            upd_pc      = ($urandom_range(0, 1) == 1) ? pred_pc : $urandom;
            pred_offset = $urandom;
            step(-1, 1'b0, "");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
